// File: rtl/nios2_jtag_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nios2_jtag_ocimem_arbiter
// Description : Shares the single-port on-chip debug RAM between the JTAG
//               debug command path and the CPU-side Avalon debug slave.
//               JTAG commands land in a one-entry pending register; a
//               round-robin FSM sequences one RAM access at a time.
// Ports       : clk, reset_n                  clock, async active-low reset
//               jdo, take_*_ocimem_*          JTAG command data and strobes
//               av_*                          Avalon debug slave
//               ram_*                         single-port debug RAM
//               MonDReg, monitor_ready/error  JTAG read data and status
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_jtag_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32   // JTAG data field is 32 bits, keep at 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        J_RD  = 3'd1,
        J_CAP = 3'd2,
        J_WR  = 3'd3,
        A_RD  = 3'd4,
        A_CAP = 3'd5,
        A_WR  = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_jaddr;
    logic              r_pend;
    logic              r_pend_wr;
    logic [31:0]       r_pend_wdata;
    logic              r_last_av;      // 1: Avalon was granted most recently
    logic              r_ready;
    logic              r_error;
    logic [31:0]       r_mon;

    logic w_sel_a;
    logic w_sel_b;
    logic w_sel_na;
    logic w_req;
    logic w_complete;
    logic w_busy;
    logic w_av_req;
    logic w_grant_j;
    logic w_grant_a;
    logic w_unused_jdo;

    // Strobe priority: b over a over no_action_a.
    assign w_sel_b  = take_action_ocimem_b;
    assign w_sel_a  = take_action_ocimem_a & ~take_action_ocimem_b;
    assign w_sel_na = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    assign w_req    = w_sel_b | (w_sel_a & jdo[35]) | w_sel_na;

    // The pending entry is being retired this cycle, so a new command can
    // take its place without counting as an overrun.
    assign w_complete = (r_state == J_WR) || (r_state == J_CAP);
    assign w_busy     = r_pend & ~w_complete;
    assign w_av_req   = av_read | av_write;

    assign w_unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // ------------------------------------------------------------------
    // Next-state / grant logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_j   = 1'b0;
        w_grant_a   = 1'b0;
        case (r_state)
            IDLE: begin
                // On contention the side not granted last time wins.
                if (r_pend && (!w_av_req || r_last_av)) begin
                    w_grant_j   = 1'b1;
                    w_state_nxt = r_pend_wr ? J_WR : J_RD;
                end else if (w_av_req) begin
                    w_grant_a   = 1'b1;
                    w_state_nxt = av_write ? A_WR : A_RD;
                end
            end
            J_RD:    w_state_nxt = J_CAP;
            J_CAP:   w_state_nxt = IDLE;
            J_WR:    w_state_nxt = IDLE;
            A_RD:    w_state_nxt = A_CAP;
            A_CAP:   w_state_nxt = IDLE;
            A_WR:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RAM / Avalon outputs decoded from the current state
    // ------------------------------------------------------------------
    always_comb begin
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        av_readdata = '0;
        case (r_state)
            J_RD: begin
                ram_re   = 1'b1;
                ram_addr = r_jaddr;
            end
            J_WR: begin
                ram_we    = 1'b1;
                ram_addr  = r_jaddr;
                ram_wdata = DATA_W'(r_pend_wdata);
            end
            A_RD: begin
                ram_re   = 1'b1;
                ram_addr = av_address;
            end
            A_WR: begin
                ram_we    = 1'b1;
                ram_addr  = av_address;
                ram_wdata = av_writedata;
            end
            A_CAP:   av_readdata = ram_rdata;
            default: ;
        endcase
    end

    assign av_waitrequest = w_av_req & ~((r_state == A_WR) || (r_state == A_CAP));
    assign MonDReg        = r_mon;
    assign monitor_ready  = r_ready;
    assign monitor_error  = r_error;

    // ------------------------------------------------------------------
    // State, JTAG intake and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_jaddr      <= '0;
            r_pend       <= 1'b0;
            r_pend_wr    <= 1'b0;
            r_pend_wdata <= '0;
            r_last_av    <= 1'b0;
            r_ready      <= 1'b1;
            r_error      <= 1'b0;
            r_mon        <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant_j) begin
                r_last_av <= 1'b0;
            end else if (w_grant_a) begin
                r_last_av <= 1'b1;
            end

            // A fresh address load takes precedence over the post-access
            // increment.
            if (w_sel_a) begin
                r_jaddr <= jdo[17 +: ADDR_W];
            end else if (w_complete) begin
                r_jaddr <= r_jaddr + ADDR_W'(1);
            end

            if (w_req && !w_busy) begin
                r_pend       <= 1'b1;
                r_pend_wr    <= w_sel_b;
                r_pend_wdata <= jdo[34:3];
            end else if (w_complete) begin
                r_pend <= 1'b0;
            end

            // An overrun on an ocimem_a read strobe still reports the error.
            if (w_req && w_busy) begin
                r_error <= 1'b1;
            end else if (w_sel_a) begin
                r_error <= 1'b0;
            end

            // Ready drops one cycle after a command is queued.
            if (w_complete) begin
                r_ready <= 1'b1;
            end else if (r_pend) begin
                r_ready <= 1'b0;
            end

            if (r_state == J_CAP) begin
                r_mon <= ram_rdata[31:0];
            end
        end
    end

endmodule
`default_nettype wire
